// File: rtl/seg7_scan_mux.sv
// Time-multiplexes NUM_DIG 7-segment patterns onto one shared bus with one-hot digit enables,
// a blank gap at the start of each slot, and a frame tick. Optional macro: SCAN_BRIGHT_EN (duty control).
module seg7_scan_mux #(
  parameter int         NUM_DIG   = 3,
  parameter int         SCAN_DIV  = 16,
  parameter int         BLANK_CYC = 2,
  parameter logic [6:0] SEG_OFF   = 7'b1111111
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [7*NUM_DIG-1:0]       seg_in,
  input  logic [NUM_DIG-1:0]         dpt_in,
`ifdef SCAN_BRIGHT_EN
  input  logic [2:0]                 bright,
`endif
  output logic [6:0]                 seg_out,
  output logic                       dpt_out,
  output logic [NUM_DIG-1:0]         dig_sel,
  output logic [$clog2(NUM_DIG)-1:0] scan_idx,
  output logic                       frame_tick
);

  localparam int K_W   = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIG);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);

  // First slot count (exclusive) at which the digit goes dark again for a duty level 0..7.
  function automatic int show_end(input logic [2:0] level);
    show_end = BLANK_CYC + (((SCAN_DIV - BLANK_CYC) * (int'(level) + 1)) >> 3);
  endfunction

  logic [K_W-1:0]   k;
  logic [K_W-1:0]   k_n;
  logic [IDX_W-1:0] idx_n;
  logic [2:0]       level_n;
  logic             run;
  logic             show_n;
  logic             enter_n;
  logic             tick_n;
  logic [6:0]       seg_sel;
  logic             dpt_sel;

`ifdef SCAN_BRIGHT_EN
  logic [2:0] bright_q;
`endif

  always_comb begin
    run     = en && !rst;
    k_n     = '0;
    idx_n   = '0;
    if (run) begin
      if (k == K_LAST) begin
        k_n   = '0;
        idx_n = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
        k_n   = k + 1'b1;
        idx_n = scan_idx;
      end
    end
`ifdef SCAN_BRIGHT_EN
    level_n = (k_n == '0) ? bright : bright_q;
`else
    level_n = 3'd7;
`endif
    show_n  = run && (int'(k_n) >= BLANK_CYC) && (int'(k_n) < show_end(level_n));
    // A slot's first SHOW cycle captures; the dig_sel==0 term covers the first slot after a
    // restart when BLANK_CYC=0, whose k=0 cycle was forced dark.
    enter_n = show_n && ((int'(k_n) == BLANK_CYC) || (dig_sel == '0));
    tick_n  = run && (k_n == K_LAST) && (idx_n == IDX_LAST);
    seg_sel = seg_in[7*int'(idx_n) +: 7];
    dpt_sel = dpt_in[idx_n];
  end

  // ---- registered scan state and display outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      k          <= '0;
      scan_idx   <= '0;
      seg_out    <= SEG_OFF;
      dpt_out    <= 1'b1;
      dig_sel    <= '0;
      frame_tick <= 1'b0;
    end else begin
      k          <= k_n;
      scan_idx   <= idx_n;
      frame_tick <= tick_n;
      dig_sel    <= show_n ? (NUM_DIG'(1) << idx_n) : '0;
      if (enter_n) begin
        seg_out <= seg_sel;
        dpt_out <= ~dpt_sel;  // dot request is active-high, the shared dot line is active-low
      end else if (!show_n) begin
        seg_out <= SEG_OFF;
        dpt_out <= 1'b1;
      end
    end
  end

`ifdef SCAN_BRIGHT_EN
  always_ff @(posedge clk) begin
    if (rst || (k_n == '0)) bright_q <= bright;
  end
`endif

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: a cycle model of the default instance pushes the expected
// outputs at each edge; extra instances cover the gapless and (with SCAN_BRIGHT_EN) dark-slot cases.
module tb_seg7_scan_mux;

  typedef struct {
    logic [6:0] seg;
    logic       dpt;
    logic [2:0] dig;
    logic [1:0] idx;
    logic       tick;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [20:0] seg_in = {7'h79, 7'h24, 7'h40};
  logic [2:0]  dpt_in = 3'b010;
  logic [6:0]  seg_out;
  logic        dpt_out;
  logic [2:0]  dig_sel;
  logic [1:0]  scan_idx;
  logic        frame_tick;

  logic [27:0] seg_in1 = {7'h01, 7'h02, 7'h03, 7'h04};
  logic [3:0]  dpt_in1 = 4'b0000;
  logic [6:0]  seg_out1;
  logic        dpt_out1;
  logic [3:0]  dig_sel1;
  logic [1:0]  scan_idx1;
  logic        frame_tick1;

  int checks = 0;
  int errors = 0;

  int   mk = 0;
  int   midx = 0;
  logic mshow = 1'b0;
  logic [6:0] mseg = 7'h7F;
  logic mdpt = 1'b1;
  logic mtick = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

`ifdef SCAN_BRIGHT_EN
  logic [2:0] bright = 3'd7;
  logic [2:0] bright2 = 3'd2;
  int         mbq = 7;
  logic [6:0] seg_out2;
  logic       dpt_out2;
  logic [2:0] dig_sel2;
  logic [1:0] scan_idx2;
  logic       frame_tick2;

  seg7_scan_mux u0 (.clk(clk), .rst(rst), .en(en), .seg_in(seg_in), .dpt_in(dpt_in),
    .bright(bright), .seg_out(seg_out), .dpt_out(dpt_out), .dig_sel(dig_sel),
    .scan_idx(scan_idx), .frame_tick(frame_tick));
  seg7_scan_mux #(.NUM_DIG(4), .SCAN_DIV(2), .BLANK_CYC(0)) u1 (.clk(clk), .rst(rst), .en(en),
    .seg_in(seg_in1), .dpt_in(dpt_in1), .bright(3'd7), .seg_out(seg_out1), .dpt_out(dpt_out1),
    .dig_sel(dig_sel1), .scan_idx(scan_idx1), .frame_tick(frame_tick1));
  seg7_scan_mux #(.NUM_DIG(3), .SCAN_DIV(4), .BLANK_CYC(2)) u2 (.clk(clk), .rst(rst), .en(en),
    .seg_in(seg_in), .dpt_in(dpt_in), .bright(bright2), .seg_out(seg_out2), .dpt_out(dpt_out2),
    .dig_sel(dig_sel2), .scan_idx(scan_idx2), .frame_tick(frame_tick2));
`else
  seg7_scan_mux u0 (.clk(clk), .rst(rst), .en(en), .seg_in(seg_in), .dpt_in(dpt_in),
    .seg_out(seg_out), .dpt_out(dpt_out), .dig_sel(dig_sel),
    .scan_idx(scan_idx), .frame_tick(frame_tick));
  seg7_scan_mux #(.NUM_DIG(4), .SCAN_DIV(2), .BLANK_CYC(0)) u1 (.clk(clk), .rst(rst), .en(en),
    .seg_in(seg_in1), .dpt_in(dpt_in1), .seg_out(seg_out1), .dpt_out(dpt_out1),
    .dig_sel(dig_sel1), .scan_idx(scan_idx1), .frame_tick(frame_tick1));
`endif

  // Advance the model across one edge using the inputs in place before it, then compare.
  task automatic step();
    exp_t e;
    int   len;
    logic show;
    if (rst || !en) begin
      mk = 0; midx = 0; mshow = 1'b0; mseg = 7'h7F; mdpt = 1'b1; mtick = 1'b0;
`ifdef SCAN_BRIGHT_EN
      mbq = int'(bright);
`endif
    end else begin
      if (mk == 15) begin
        mk = 0;
        midx = (midx == 2) ? 0 : midx + 1;
      end else begin
        mk = mk + 1;
      end
`ifdef SCAN_BRIGHT_EN
      if (mk == 0) mbq = int'(bright);
      len = (14 * (mbq + 1)) / 8;
`else
      len = 14;
`endif
      show = (mk >= 2) && (mk < 2 + len);
      if (show && (!mshow || mk == 2)) begin
        mseg = seg_in[7*midx +: 7];
        mdpt = ~dpt_in[midx];
      end else if (!show) begin
        mseg = 7'h7F;
        mdpt = 1'b1;
      end
      mshow = show;
      mtick = (midx == 2) && (mk == 15);
    end
    e.seg  = mseg;
    e.dpt  = mdpt;
    e.dig  = mshow ? (3'b001 << midx) : 3'b000;
    e.idx  = 2'(midx);
    e.tick = mtick;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if ({seg_out, dpt_out, dig_sel, scan_idx, frame_tick} !== {e.seg, e.dpt, e.dig, e.idx, e.tick}) begin
      errors++;
      $display("FAIL scoreboard k=%0d idx=%0d: got seg=%h dpt=%b dig=%b idx=%0d tick=%b, want seg=%h dpt=%b dig=%b idx=%0d tick=%b",
               mk, midx, seg_out, dpt_out, dig_sel, scan_idx, frame_tick,
               e.seg, e.dpt, e.dig, e.idx, e.tick);
    end
  endtask

  task automatic run_to(input int idx, input int kk);
    int n = 0;
    while (!(midx == idx && mk == kk) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (!(midx == idx && mk == kk)) begin
      errors++;
      $display("FAIL run_to timeout: at idx=%0d k=%0d, want idx=%0d k=%0d", midx, mk, idx, kk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    step();
    step();
    checks++;
    if ({seg_out, dpt_out, dig_sel, scan_idx, frame_tick} !== {7'h7F, 1'b1, 3'b000, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got seg=%h dpt=%b dig=%b idx=%0d tick=%b, want 7f 1 000 0 0",
               seg_out, dpt_out, dig_sel, scan_idx, frame_tick);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    int ticks = 0;
    int on_cnt = 0;
    for (int c = 0; c < 144; c++) begin
      step();
      if (frame_tick) ticks++;
      if (dig_sel == 3'b010 && seg_out == 7'h24 && dpt_out == 1'b0) on_cnt++;
    end
    checks++;
    if (ticks != 3) begin
      errors++;
      $display("FAIL frame_tick_count: got %0d, want 3", ticks);
    end
    checks++;
    if (on_cnt != 42) begin
      errors++;
      $display("FAIL digit1_show_cycles: got %0d, want 42", on_cnt);
    end
  endtask

  task automatic test_midslot_change();
    run_to(0, 5);
    seg_in[6:0] = 7'h06;
    for (int c = 6; c < 16; c++) begin
      step();
      checks++;
      if (seg_out !== 7'h40 || dig_sel !== 3'b001) begin
        errors++;
        $display("FAIL midslot_hold k=%0d: got seg=%h dig=%b, want 40 001", mk, seg_out, dig_sel);
      end
    end
    run_to(0, 2);
    checks++;
    if (seg_out !== 7'h06 || dig_sel !== 3'b001) begin
      errors++;
      $display("FAIL midslot_new: got seg=%h dig=%b, want 06 001", seg_out, dig_sel);
    end
  endtask

  task automatic test_reset_midslot();
    run_to(1, 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({seg_out, dpt_out, dig_sel, scan_idx, frame_tick} !== {7'h7F, 1'b1, 3'b000, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_midslot: got seg=%h dpt=%b dig=%b idx=%0d, want 7f 1 000 0",
               seg_out, dpt_out, dig_sel, scan_idx);
    end
    step();
    step();
    checks++;
    if (dig_sel !== 3'b001 || scan_idx !== 2'd0 || seg_out !== 7'h06) begin
      errors++;
      $display("FAIL reset_restart: got dig=%b idx=%0d seg=%h, want 001 0 06", dig_sel, scan_idx, seg_out);
    end
  endtask

  task automatic test_enable();
    run_to(1, 3);
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (dig_sel !== 3'b000 || seg_out !== 7'h7F) begin
        errors++;
        $display("FAIL en_low_dark c=%0d: got dig=%b seg=%h, want 000 7f", c, dig_sel, seg_out);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (dig_sel !== 3'b000) begin
      errors++;
      $display("FAIL en_restart_k1: got dig=%b, want 000", dig_sel);
    end
    step();
    checks++;
    if (dig_sel !== 3'b001 || seg_out !== 7'h06) begin
      errors++;
      $display("FAIL en_restart_k2: got dig=%b seg=%h, want 001 06", dig_sel, seg_out);
    end
  endtask

  task automatic test_no_gap();
    logic [3:0] want;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (dig_sel1 !== 4'b0000) begin
      errors++;
      $display("FAIL nogap_reset: got dig=%b, want 0000", dig_sel1);
    end
    for (int c = 1; c <= 16; c++) begin
      step();
      want = 4'b0001 << ((c / 2) % 4);
      checks++;
      if (dig_sel1 !== want || frame_tick1 !== ((c % 8) == 7)) begin
        errors++;
        $display("FAIL nogap_walk c=%0d: got dig=%b tick=%b, want dig=%b tick=%b",
                 c, dig_sel1, frame_tick1, want, ((c % 8) == 7));
      end
    end
  endtask

`ifdef SCAN_BRIGHT_EN
  task automatic test_bright();
    int on_cnt = 0;
    int dark_bad = 0;
    bright = 3'd3;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 48; c++) begin
      step();
      if (dig_sel != 3'b000) on_cnt++;
      if (dig_sel2 != 3'b000) dark_bad++;
    end
    checks++;
    if (on_cnt != 21) begin
      errors++;
      $display("FAIL bright3_on_cycles: got %0d, want 21", on_cnt);
    end
    checks++;
    if (dark_bad != 0) begin
      errors++;
      $display("FAIL bright_zero_len: got %0d lit cycles, want 0", dark_bad);
    end
    bright = 3'd7;
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_midslot_change();
    test_reset_midslot();
    test_enable();
    test_no_gap();
`ifdef SCAN_BRIGHT_EN
    test_bright();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
